reg_bank: RTL and testbench
===========================

// Module: reg_bank
// PURPOSE
//   Integer register file x0..x31 for the single-cycle RV32I core. Supplies the two
//   signed operands the ALU consumes (rs1 -> operand A, rs2 -> operand B) and accepts
//   the ALU/writeback result into rd.
//   Storage array carries no async reset so it maps to distributed RAM. After reset,
//   a sequential clear engine sweeps the array; oReady gates the core PC.
// PARAMETERS
//   DATA_W    32             register width
//   NUM_REGS  32             number of architectural registers (power of 2)
//   ADDR_W    5              log2(NUM_REGS)
//   SP_INIT   32'h00003FFC   value loaded into x2 (sp) at end of clear
//   GP_INIT   32'h00001800   value loaded into x3 (gp) at end of clear
// PORTS
//   iCLK        in   1       core clock, rising edge
//   iRST        in   1       asynchronous reset, active-high
//   iRegWrite   in   1       write enable for rd
//   iWriteReg   in   ADDR_W  rd address
//   iWriteData  in   DATA_W  writeback data
//   iReadReg1   in   ADDR_W  rs1 address
//   iReadReg2   in   ADDR_W  rs2 address
//   oReadData1  out  DATA_W  rs1 data, combinational
//   oReadData2  out  DATA_W  rs2 data, combinational
//   oReady      out  1       1 = clear finished, bank usable
// BEHAVIOUR
//   - Reset: iRST high -> state CLEAR, sweep index = 0, oReady = 0. Both read data
//     outputs read 0 while in CLEAR.
//   - FSM CLEAR: each cycle writes 0 to entry[index] and increments the index.
//     * At index = NUM_REGS-1: write that entry, then load entry[2] = SP_INIT and
//       entry[3] = GP_INIT on the same edge, then go to RUN.
//     * Clear takes exactly NUM_REGS cycles; oReady rises on the cycle after the last sweep edge.
//   - FSM RUN: terminal state; left only via iRST.
//   - iRST asserted mid-sweep: the index returns to 0 and the sweep restarts from the beginning.
//   - Write: in RUN only. On rising iCLK with iRegWrite = 1 and iWriteReg != 0,
//     entry[iWriteReg] <= iWriteData. Writes are ignored entirely during CLEAR.
//   - x0: the write is dropped; reads of address 0 always return 0, in every state.
//   - Read: combinational from the array. Latency is 0 cycles; data is valid in the same
//     cycle as the address.
//   - Bypass (write-first): in RUN, when iRegWrite = 1 and iWriteReg = iReadRegN != 0,
//     oReadDataN = iWriteData in that same cycle. Both ports bypass independently,
//     and both may hit the same register.
//   - Width: the data path is pass-through with no sign or zero extension. Operands are
//     treated as raw bits; the ALU interprets them as signed.
//   - Addresses are exactly ADDR_W bits, so no out-of-range index exists.
// CONFIGURATION
//   REG_DEBUG_EN defined: adds ports iDispReg (in, ADDR_W) and oDispData (out, DATA_W).
//     oDispData is a combinational third read port with the same x0, CLEAR and bypass rules.
//     It also adds oWriteCount (out, 32), which increments on every accepted non-x0 write
//     and resets to 0 on iRST.
//   Undefined: none of these ports exist; no extra logic.
// TESTING
//   1. Reset: pulse iRST, then hold iRST = 0.
//      -> oReady = 0 for 32 cycles, then 1. x2 reads 0x00003FFC, x3 reads 0x00001800,
//         and all other registers read 0.
//   2. Write x5 = 0xDEADBEEF, next cycle read rs1 = 5.
//      -> 0xDEADBEEF. Same-cycle read with write x5 = 0x12345678 pending -> 0x12345678 (bypass).
//   3. Write x0 = 0xFFFFFFFF with rs1 = rs2 = 0.
//      -> Both outputs are 0 in that cycle and afterwards.
//   4. Write x7 = 0x55 while oReady = 0.
//      -> The write is ignored; after clear, x7 reads 0.
//   5. Assert iRST at sweep index 10; prior RUN value x9 = 0xA5.
//      -> The sweep restarts, oReady stays 0 for a full 32 cycles, and x9 reads 0.
//   6. rs1 = rs2 = 12 with write x12 = 0x80000000.
//      -> Both outputs read 0x80000000 in the same cycle. With REG_DEBUG_EN:
//         oWriteCount increments by 1.

Source files
------------

// File: rtl/reg_bank.sv
// Integer register file x0..x31 for the single-cycle RV32I core.
// Two combinational read ports (rs1, rs2) with write-first bypass, one write port (rd).
// The storage array has no reset so that it maps onto distributed RAM. After reset, a
// clear engine sweeps the array one entry per cycle and then seeds sp and gp. oReady
// gates the core PC until that sweep is done.
// Optional feature macro REG_DEBUG_EN: adds a third read port (iDispReg/oDispData)
// and an accepted-write counter (oWriteCount).
module reg_bank #(
  parameter int unsigned             DATA_W   = 32,
  parameter int unsigned             NUM_REGS = 32,
  parameter int unsigned             ADDR_W   = 5,
  parameter logic [DATA_W-1:0]       SP_INIT  = 32'h0000_3FFC,
  parameter logic [DATA_W-1:0]       GP_INIT  = 32'h0000_1800
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iRegWrite,
  input  logic [ADDR_W-1:0] iWriteReg,
  input  logic [DATA_W-1:0] iWriteData,
  input  logic [ADDR_W-1:0] iReadReg1,
  input  logic [ADDR_W-1:0] iReadReg2,
  output logic [DATA_W-1:0] oReadData1,
  output logic [DATA_W-1:0] oReadData2,
`ifdef REG_DEBUG_EN
  input  logic [ADDR_W-1:0] iDispReg,
  output logic [DATA_W-1:0] oDispData,
  output logic [31:0]       oWriteCount,
`endif
  output logic              oReady
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                clear_last;
  logic                run;
  logic                wr_acc;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];

  // Resolve one read port: x0 and the clear phase read 0; a same-cycle write to the
  // addressed register is forwarded ahead of the stored value.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              is_run,
    input logic              wr_en,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    if (!is_run || addr == '0) begin
      val = '0;
    end else if (wr_en && waddr == addr) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  assign run    = (state_q == RUN);
  assign wr_acc = run && iRegWrite && (iWriteReg != '0);
  assign oReady = run;

  // State register and sweep index; reset restarts the sweep from entry 0.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: advance the sweep, leave CLEAR after the last entry.
  // NOTE: every output of this block is given a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clear_last = 1'b0;
    unique case (state_q)
      CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          clear_last = 1'b1;
          idx_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Storage: the clear sweep owns the write port in CLEAR, the core owns it in RUN.
  // NOTE: the array deliberately has no reset; the sweep initialises it instead, which
  // keeps it mappable to distributed RAM.
  always_ff @(posedge iCLK) begin
    if (state_q == CLEAR) begin
      mem_q[idx_q] <= '0;
      if (clear_last) begin
        mem_q[2] <= SP_INIT;
        mem_q[3] <= GP_INIT;
      end
    end else if (wr_acc) begin
      mem_q[iWriteReg] <= iWriteData;
    end
  end

  // Combinational read ports with write-first bypass.
  always_comb begin
    oReadData1 = read_mux(iReadReg1, mem_q[iReadReg1], run, wr_acc, iWriteReg, iWriteData);
    oReadData2 = read_mux(iReadReg2, mem_q[iReadReg2], run, wr_acc, iWriteReg, iWriteData);
  end

`ifdef REG_DEBUG_EN
  logic [31:0] wcount_q, wcount_d;

  assign wcount_d    = wcount_q + 32'd1;
  assign oWriteCount = wcount_q;

  // Debug display port follows the same x0, CLEAR and bypass rules as rs1/rs2.
  always_comb begin
    oDispData = read_mux(iDispReg, mem_q[iDispReg], run, wr_acc, iWriteReg, iWriteData);
  end

  // Count every accepted non-x0 write.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wcount_q <= '0;
    end else if (wr_acc) begin
      wcount_q <= wcount_d;
    end
  end
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank. Expected values come from a bench-side register
// model; they are queued when stimulus is applied and compared once outputs settle.
// Define REG_DEBUG_EN to also exercise the debug port and write counter.
module tb_reg_bank;

  localparam logic [31:0] SP_INIT = 32'h0000_3FFC;
  localparam logic [31:0] GP_INIT = 32'h0000_1800;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iRegWrite;
  logic [4:0]  iWriteReg;
  logic [31:0] iWriteData;
  logic [4:0]  iReadReg1;
  logic [4:0]  iReadReg2;
  logic [31:0] oReadData1;
  logic [31:0] oReadData2;
  logic        oReady;
`ifdef REG_DEBUG_EN
  logic [4:0]  iDispReg;
  logic [31:0] oDispData;
  logic [31:0] oWriteCount;
`endif

  reg_bank dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iRegWrite  (iRegWrite),
    .iWriteReg  (iWriteReg),
    .iWriteData (iWriteData),
    .iReadReg1  (iReadReg1),
    .iReadReg2  (iReadReg2),
    .oReadData1 (oReadData1),
    .oReadData2 (oReadData2),
`ifdef REG_DEBUG_EN
    .iDispReg   (iDispReg),
    .oDispData  (oDispData),
    .oWriteCount(oWriteCount),
`endif
    .oReady     (oReady)
  );

  always #5 iCLK = ~iCLK;

  typedef enum int {P_RD1, P_RD2, P_READY, P_DISP, P_WCNT} port_t;

  typedef struct {
    string       tag;
    port_t       port;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] model_mem [32];
  logic        model_run;
  logic [31:0] model_wcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr, input logic we,
                                             input logic [4:0] wreg, input logic [31:0] wdata);
    if (!model_run || addr == 5'd0) return 32'h0;
    if (we && wreg == addr) return wdata;
    return model_mem[addr];
  endfunction

  task automatic sb_push(input string tag, input port_t port, input logic [31:0] exp);
    sb_item_t it;
    it.tag  = tag;
    it.port = port;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_drain();
    sb_item_t    it;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      it  = sb_q.pop_front();
      got = 32'hX;
      case (it.port)
        P_RD1:   got = oReadData1;
        P_RD2:   got = oReadData2;
        P_READY: got = {31'd0, oReady};
`ifdef REG_DEBUG_EN
        P_DISP:  got = oDispData;
        P_WCNT:  got = oWriteCount;
`endif
        default: got = 32'hX;
      endcase
      check(it.tag, got, it.exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check mid-cycle, update model at the
  // rising edge, return at the next falling edge.
  task automatic cycle(input string tag, input logic we, input logic [4:0] wreg,
                       input logic [31:0] wdata, input logic [4:0] r1, input logic [4:0] r2);
    iRegWrite  = we;
    iWriteReg  = wreg;
    iWriteData = wdata;
    iReadReg1  = r1;
    iReadReg2  = r2;
`ifdef REG_DEBUG_EN
    iDispReg   = wreg;
`endif
    #1;
    sb_push($sformatf("%s ready", tag), P_READY, {31'd0, model_run});
    sb_push($sformatf("%s rd1 x%0d", tag, r1), P_RD1, model_read(r1, we, wreg, wdata));
    sb_push($sformatf("%s rd2 x%0d", tag, r2), P_RD2, model_read(r2, we, wreg, wdata));
`ifdef REG_DEBUG_EN
    sb_push($sformatf("%s disp x%0d", tag, wreg), P_DISP, model_read(wreg, we, wreg, wdata));
    sb_push($sformatf("%s wcnt", tag), P_WCNT, model_wcnt);
`endif
    sb_drain();
    @(posedge iCLK);
    if (model_run && we && wreg != 5'd0) begin
      model_mem[wreg] = wdata;
      model_wcnt      = model_wcnt + 32'd1;
    end
    @(negedge iCLK);
  endtask

  task automatic model_reset();
    model_run  = 1'b0;
    model_wcnt = 32'd0;
  endtask

  // Sweep: 32 cycles with oReady low, optionally attempting writes to x7 that must be
  // ignored, then the model takes on the cleared contents.
  task automatic sweep(input string tag, input int n_cycles);
    for (int i = 0; i < n_cycles; i++) begin
      cycle($sformatf("%s c%0d", tag, i), (i % 3 == 0), 5'd7, 32'h55, 5'd2, 5'(i));
    end
  endtask

  task automatic finish_sweep();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    model_mem[2] = SP_INIT;
    model_mem[3] = GP_INIT;
    model_run    = 1'b1;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i += 2) begin
      cycle(tag, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));
    end
  endtask

  initial begin
    iRST       = 1'b1;
    iRegWrite  = 1'b0;
    iWriteReg  = 5'd0;
    iWriteData = 32'h0;
    iReadReg1  = 5'd0;
    iReadReg2  = 5'd0;
`ifdef REG_DEBUG_EN
    iDispReg   = 5'd0;
`endif
    model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;

    // Reset and full clear sweep; writes to x7 during the sweep are dropped.
    repeat (2) @(negedge iCLK);
    #1;
    sb_push("reset ready", P_READY, 32'd0);
    sb_push("reset rd1", P_RD1, 32'd0);
    sb_drain();
    @(negedge iCLK);
    iRST = 1'b0;
    sweep("clr", 32);
    finish_sweep();
    read_all("post-clr");

    // Write then read, and same-cycle bypass on rs1 only.
    cycle("wr x5", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
    cycle("rd x5", 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    cycle("byp x5", 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd6);
    cycle("rd x5 new", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

    // x0 writes are dropped.
    cycle("wr x0", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    cycle("rd x0", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Both ports bypass the same register.
    cycle("byp x12", 1'b1, 5'd12, 32'h8000_0000, 5'd12, 5'd12);
    cycle("rd x12", 1'b0, 5'd0, 32'h0, 5'd12, 5'd12);

    // Randomised write/read mix against the model.
    for (int i = 0; i < 40; i++) begin
      cycle($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Mid-sweep reset: x9 gets a value in RUN, then the sweep restarts from zero.
    cycle("wr x9", 1'b1, 5'd9, 32'hA5, 5'd0, 5'd0);
    cycle("rd x9", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    iRST = 1'b1;
    model_reset();
    @(negedge iCLK);
    iRST = 1'b0;
    sweep("part", 10);
    iRST = 1'b1;
    #1;
    sb_push("midrst ready", P_READY, 32'd0);
    sb_drain();
    @(negedge iCLK);
    iRST = 1'b0;
    sweep("reclr", 32);
    finish_sweep();
    read_all("post-reclr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
